// File: rtl/rr_onehot_req_arb_if.sv
// Request/grant bundle for the round-robin one-hot arbiter.
// The slave modport is the arbiter side. The master modport is the requester side.
interface rr_onehot_req_arb_if #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8
);
  logic [N_REQ-1:0] req;
  logic             release_i;
  logic [N_REQ-1:0] grant_4b;
  logic             start_a;
  logic             done_b;
  logic             busy;
  logic [CNT_W-1:0] grant_cnt;

  modport master (
    output req, release_i,
    input  grant_4b, start_a, done_b, busy, grant_cnt
  );

  modport slave (
    input  req, release_i,
    output grant_4b, start_a, done_b, busy, grant_cnt
  );
endinterface

// File: rtl/rr_onehot_req_arb.sv
// Round-robin arbiter producing a registered one-hot-or-zero grant.
// Each grant is held for HOLD_CYC cycles and is framed by a start_a pulse and a done_b pulse.
// An early release ends the grant without a done_b pulse.
// Every grant is followed by a one-cycle GAP and then an IDLE sampling cycle.
// A saturating counter tracks how many grants have been issued.
module rr_onehot_req_arb #(
  parameter int N_REQ    = 4,
  parameter int HOLD_CYC = 10,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_onehot_req_arb_if.slave   bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               start_q, start_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               win_vld;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   scan_idx;

  // Saturating increment: the count holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Scan from the rotating pointer upward; the first requester found wins.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = PTR_W'((int'(ptr_q) + i) % N_REQ);
      if (!win_vld && bus.req[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  // Next-state and next-output logic. Every output defaults to holding or clearing.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (win_vld) begin
          grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          start_d = 1'b1;
          state_d = HOLD;
          hold_d  = CNT_W'(HOLD_CYC - 1);
          ptr_d   = PTR_W'((int'(win_idx) + 1) % N_REQ);
          cnt_d   = sat_inc(cnt_q);
        end
      end
      HOLD: begin
        // Release takes priority over expiry, so a released grant never reports done.
        if (bus.release_i) begin
          grant_d = '0;
          state_d = GAP;
        end else if (hold_q == '0) begin
          grant_d = '0;
          done_d  = 1'b1;
          state_d = GAP;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      GAP: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. An asynchronous reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      grant_q <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      start_q <= start_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.grant_4b  = grant_q;
  assign bus.start_a   = start_q;
  assign bus.done_b    = done_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.grant_cnt = cnt_q;

endmodule

// File: doc/rr_onehot_req_arb.md
Name: rr_onehot_req_arb

Overview:
- Round-robin arbiter that sits directly upstream of the qualification/checker stage.
- Converts up to four raw request lines into a registered one-hot-or-zero grant vector that feeds the downstream 4-bit onehot0-checked input.
- Generates a start pulse and, a fixed hold time later, a done pulse. With the default hold of 10, these satisfy the downstream "a ##10 b" sequence.
- Keeps a saturating 8-bit count of grants issued.

Parameters:
- N_REQ, 4, number of requesters; the block is specified and verified only at 4.
- HOLD_CYC, 10, cycles a grant stays asserted. Legal range 1..255.
- CNT_W, 8, width of the grant counter and hold counter.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N_REQ  request lines; level-sensitive; bit i = requester i.
- release_i  input  1  early release of the current grant; honoured only in HOLD.
- grant_4b  output  N_REQ  registered grant; always one-hot or zero.
- start_a  output  1  one-cycle pulse in the first cycle of each grant.
- done_b  output  1  one-cycle pulse exactly HOLD_CYC cycles after start_a, for a grant not released early.
- busy  output  1  high in HOLD and GAP.
- grant_cnt  output  CNT_W  total grants issued; saturates at 2^CNT_W-1.

Behaviour:
- Reset (async assert, sync-to-clk deassert is handled externally):
  - grant_4b=0, start_a=0, done_b=0, busy=0, grant_cnt=0.
  - State=IDLE, rr pointer=0, hold counter=0.
- States: IDLE, HOLD, GAP.
- IDLE:
  - If req==0, stay; all outputs stay 0.
  - If req!=0 at edge T, select the winner by scanning from index ptr upward, mod N_REQ; the first set bit wins.
  - At T+1: grant_4b=1<<winner, start_a=1, busy=1, state=HOLD, hold counter=HOLD_CYC-1, ptr=(winner+1) mod N_REQ, grant_cnt+=1 unless saturated.
- HOLD:
  - grant_4b stays stable; start_a=0 after the first cycle.
  - req changes are ignored.
  - The hold counter decrements each cycle. When it is 0 at an edge, the next cycle has grant_4b=0, done_b=1, state=GAP.
  - Net timing: grant is high for exactly HOLD_CYC cycles. done_b is high in cycle T+1+HOLD_CYC.
  - HOLD_CYC=1: start_a is high in one cycle; done_b and grant_4b=0 follow in the next cycle.
- release_i:
  - If release_i=1 at an edge while in HOLD, grant_4b=0 next cycle, state=GAP, and done_b is not asserted.
  - If release_i and counter==0 occur at the same edge, release wins: no done_b.
  - ptr and grant_cnt are not rolled back.
  - release_i is ignored in IDLE and GAP.
- GAP:
  - Lasts exactly one cycle; grant_4b=0, busy=1.
  - done_b is high only if entered by expiry.
  - Next state is IDLE; req is not sampled in GAP.
  - Minimum grant-off time between consecutive grants is therefore 2 cycles: the GAP cycle plus the IDLE sampling cycle.
- Round-robin:
  - The last winner gets lowest priority next time.
  - Fairness: with all requests held high, each requester is granted once per N_REQ grants.
- grant_cnt:
  - Increments by 1 per grant issued.
  - Holds at 255 once it reaches 255; no wrap.
- Invariants the bench must assert every cycle:
  - $onehot0(grant_4b).
  - start_a implies a grant is present and equals that of the previous IDLE decision.
  - done_b implies grant_4b==0.
  - start_a and done_b are never high together.
- Reset mid-operation: asserting rst_n=0 in any state clears all outputs immediately, without waiting for a clock edge. After release, arbitration restarts with ptr=0.

Test Plan:
- Reset: assert rst_n=0 for 3 cycles, then release with req=0 -> all outputs 0; grant_cnt=0; busy=0 for 5 idle cycles.
- Single request: req=4'b0100 sampled at T -> grant_4b=4'b0100 and start_a=1 at T+1; grant held through T+10; done_b=1 with grant_4b=0 at T+11; grant_cnt=1.
- Round-robin: req=4'b1111 held -> grants 0001, 0010, 0100, 1000, 0001; each start_a is 12 cycles apart (10 hold + GAP + IDLE); grant_cnt=5.
- Early release: req=4'b0011; pulse release_i on the 4th grant cycle -> grant_4b=0 next cycle with no done_b; the next grant is 4'b0010.
- Async reset mid-HOLD: drop rst_n between edges during HOLD -> grant_4b, start_a, done_b, and busy go to 0 immediately; the first grant after reset with req=4'b1111 is 4'b0001.
- Saturation: HOLD_CYC=1, req=4'b1000 held for 300 grants -> grant_cnt stays at 255; onehot0 holds throughout.
